// File: rtl/spi_target_pkg.sv
// Shared state encoding and default geometry for the SPI mode-0 target receiver.
package spi_target_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  localparam int WORD_DEF        = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage async-reset synchroniser for one SPI pin; RST_VAL sets the idle level held through reset.
module spi_sync
  import spi_target_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target_rx.sv
// SPI mode-0 target: synchronises SCK/MOSI/CS_N into i_clk and deserialises MSB-first words.
// Define SPI_MISO_EN to build the MISO status-return shifter; otherwise o_miso/o_tx_load are tied low.
module spi_target_rx
  import spi_target_pkg::*;
#(
  parameter int WORD        = WORD_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sck,
  input  logic            i_mosi,
  input  logic            i_cs_n,
  output logic            o_miso,
  output logic [WORD-1:0] o_data,
  output logic            o_valid,
  output logic            o_frame_start,
  output logic            o_frame_end,
  output logic            o_abort,
  input  logic [WORD-1:0] i_tx_data,
  output logic            o_tx_load
);

  localparam int CW = $clog2(WORD);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD - 1);
  localparam logic [SW-1:0] SETTLED  = SW'(SYNC_STAGES);

  logic sck_s, mosi_s, csn_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sck), .o_q(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi), .o_q(mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs_n), .o_q(csn_s)
  );

  state_e          state_q;
  logic [SW-1:0]   settle_q;
  logic [CW-1:0]   cnt_q;
  logic [WORD-1:0] rx_q, rx_d, data_q;
  logic            sck_prev_q, csn_prev_q;
  logic            valid_q, start_q, end_q, abort_q;
  logic            sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = csn_prev_q & ~csn_s;
  assign cs_rise  = ~csn_prev_q & csn_s;
  assign rx_d     = {rx_q[WORD-2:0], mosi_s};

  // The CS_N synchroniser powers up reading "deasserted", so WAIT_IDLE first lets it
  // flush real pin samples; otherwise a frame in flight at reset release would look new.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= WAIT_IDLE;
      settle_q   <= '0;
      cnt_q      <= '0;
      rx_q       <= '0;
      data_q     <= '0;
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b1;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      sck_prev_q <= sck_s;
      csn_prev_q <= csn_s;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
      unique case (state_q)
        WAIT_IDLE: begin
          if (settle_q != SETTLED) begin
            settle_q <= settle_q + SW'(1);
          end else if (csn_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            start_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            end_q   <= 1'b1;
            abort_q <= (cnt_q != '0);
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (sck_rise) begin
            rx_q <= rx_d;
            if (cnt_q == LAST_BIT) begin
              data_q  <= rx_d;
              valid_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_start = start_q;
  assign o_frame_end   = end_q;
  assign o_abort       = abort_q;

`ifdef SPI_MISO_EN
  logic [WORD-1:0] tx_q;
  logic            tx_load_q;

  // Tracking i_tx_data while idle puts the next MSB on the pin as soon as CS_N falls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_q      <= '0;
      tx_load_q <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      if (state_q == IDLE) begin
        tx_q <= i_tx_data;
      end else if (state_q == ACTIVE && sck_fall) begin
        if (cnt_q == '0) begin
          tx_q      <= i_tx_data;
          tx_load_q <= 1'b1;
        end else begin
          tx_q <= {tx_q[WORD-2:0], 1'b0};
        end
      end
    end
  end

  assign o_miso    = ~csn_s & tx_q[WORD-1];
  assign o_tx_load = tx_load_q;
`else
  logic unused_tx;
  assign unused_tx = ^{i_tx_data, sck_fall};
  assign o_miso    = 1'b0;
  assign o_tx_load = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target_rx.sv
// Self-checking bench for spi_target_rx: bit-level SPI host model plus a frame-level expectation model.
`timescale 1ns/1ps
module tb_spi_target_rx;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_sck = 1'b0;
  logic         i_mosi = 1'b0;
  logic         i_cs_n = 1'b1;
  logic [W-1:0] i_tx_data = '0;
  logic         o_miso, o_valid, o_frame_start, o_frame_end, o_abort, o_tx_load;
  logic [W-1:0] o_data;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_start = 0, n_end = 0, n_abort = 0, n_lone_abort = 0, n_txload = 0;

  logic [W-1:0] got_q[$];
  logic [W-1:0] host_rx_q[$];
  logic [W-1:0] tx_words[$];
  logic [W-1:0] host_acc = '0;
  logic [W-1:0] last_word = '0;

  spi_target_rx #(.WORD(W), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sck(i_sck), .i_mosi(i_mosi), .i_cs_n(i_cs_n),
    .o_miso(o_miso), .o_data(o_data), .o_valid(o_valid), .o_frame_start(o_frame_start),
    .o_frame_end(o_frame_end), .o_abort(o_abort), .i_tx_data(i_tx_data), .o_tx_load(o_tx_load)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid) begin
        n_valid++;
        got_q.push_back(o_data);
      end
      if (o_frame_start) n_start++;
      if (o_frame_end) n_end++;
      if (o_abort) n_abort++;
      if (o_abort && !o_frame_end) n_lone_abort++;
      if (o_tx_load) n_txload++;
    end
  end

  // Host drives MOSI while SCK is low and samples MISO on the rising edge.
  task automatic host_bits(input int first, input int nbits, input int half);
    logic [W-1:0] w;
    for (int b = first; b < first + nbits; b++) begin
      w = tx_words[b / W];
      i_mosi = w[W-1-(b % W)];
      #(half);
      i_sck = 1'b1;
      host_acc = {host_acc[W-2:0], o_miso};
      if (b % W == W - 1) host_rx_q.push_back(host_acc);
      #(half);
      i_sck = 1'b0;
    end
  endtask

  task automatic host_frame(input int nbits, input int half);
    i_cs_n = 1'b0;
    host_bits(0, nbits, half);
    #(half);
    i_cs_n = 1'b1;
    i_mosi = 1'b0;
    repeat (20) @(posedge i_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_valid, o_frame_start, o_frame_end, o_abort, o_miso, o_tx_load} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b required 000000",
               {o_valid, o_frame_start, o_frame_end, o_abort, o_miso, o_tx_load});
    end
    checks++;
    if (o_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h required 00", o_data);
    end
    i_rst = 1'b0;
    repeat (10) @(negedge i_clk);
    checks++;
    if (n_valid + n_start + n_end + n_abort !== 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d pulses required 0", n_valid + n_start + n_end + n_abort);
    end
  endtask

  task automatic test_single();
    int v0 = n_valid, s0 = n_start, e0 = n_end, a0 = n_abort;
    got_q.delete();
    tx_words = '{8'hA5};
    host_frame(W, $urandom_range(60, 120));
    checks++;
    if (n_valid - v0 !== 1 || got_q.size() != 1) begin
      errors++;
      $display("FAIL single_valid: got %0d required 1", n_valid - v0);
    end else begin
      checks++;
      if (got_q[0] !== 8'hA5) begin
        errors++;
        $display("FAIL single_word: got %h required a5", got_q[0]);
      end
    end
    checks++;
    if (n_start - s0 !== 1 || n_end - e0 !== 1 || n_abort - a0 !== 0) begin
      errors++;
      $display("FAIL single_frame: got start %0d end %0d abort %0d required 1 1 0",
               n_start - s0, n_end - e0, n_abort - a0);
    end
    checks++;
    if (o_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: got %h required a5", o_data);
    end
    last_word = 8'hA5;
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid, s0 = n_start, e0 = n_end;
    got_q.delete();
    tx_words = '{8'h00, 8'hFF, 8'h3C};
    host_frame(3 * W, 60);
    checks++;
    if (n_valid - v0 !== 3 || got_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_valid: got %0d required 3", n_valid - v0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== tx_words[i]) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], tx_words[i]);
        end
      end
    end
    checks++;
    if (n_start - s0 !== 1 || n_end - e0 !== 1) begin
      errors++;
      $display("FAIL b2b_frame: got start %0d end %0d required 1 1", n_start - s0, n_end - e0);
    end
    last_word = 8'h3C;
  endtask

  task automatic test_miso();
    int t0 = n_txload, s0 = n_start;
    bit started = 1'b0;
    host_rx_q.delete();
    got_q.delete();
`ifdef SPI_MISO_EN
    tx_words = '{8'h11, 8'h22};
    i_tx_data = 8'hC3;
    fork
      host_frame(2 * W, 80);
      begin
        for (int k = 0; k < 1000 && !started; k++) begin
          @(posedge i_clk);
          started = (n_start != s0);
        end
        i_tx_data = 8'h81;
      end
    join
    checks++;
    if (!started) begin
      errors++;
      $display("FAIL miso_start: got no frame_start required one within 1000 cycles");
    end
    checks++;
    if (host_rx_q.size() != 2) begin
      errors++;
      $display("FAIL miso_words: got %0d required 2", host_rx_q.size());
    end else begin
      checks++;
      if (host_rx_q[0] !== 8'hC3 || host_rx_q[1] !== 8'h81) begin
        errors++;
        $display("FAIL miso_data: got %h %h required c3 81", host_rx_q[0], host_rx_q[1]);
      end
    end
    checks++;
    if (n_txload - t0 !== 2) begin
      errors++;
      $display("FAIL miso_txload: got %0d required 2", n_txload - t0);
    end
    last_word = 8'h22;
`else
    tx_words = '{8'h55};
    i_tx_data = 8'hFF;
    host_frame(W, 80);
    checks++;
    if (host_rx_q.size() != 1 || host_rx_q[0] !== 8'h00) begin
      errors++;
      $display("FAIL miso_off: got %0d words first %h required 1 word 00",
               host_rx_q.size(), host_rx_q.size() > 0 ? host_rx_q[0] : 8'hxx);
    end
    checks++;
    if (o_data !== 8'h55 || n_txload - t0 !== 0) begin
      errors++;
      $display("FAIL miso_off_data: got %h txload %0d required 55 0", o_data, n_txload - t0);
    end
    last_word = 8'h55;
`endif
    i_tx_data = 8'hFF;
    repeat (5) @(negedge i_clk);
    checks++;
    if (o_miso !== 1'b0) begin
      errors++;
      $display("FAIL miso_idle: got %b required 0", o_miso);
    end
  endtask

  task automatic test_abort();
    int v0 = n_valid, e0 = n_end, a0 = n_abort, l0 = n_lone_abort;
    tx_words = '{8'hE9};
    host_frame(5, 70);
    checks++;
    if (n_valid - v0 !== 0 || n_end - e0 !== 1 || n_abort - a0 !== 1 || n_lone_abort - l0 !== 0) begin
      errors++;
      $display("FAIL abort_pulses: got valid %0d end %0d abort %0d lone %0d required 0 1 1 0",
               n_valid - v0, n_end - e0, n_abort - a0, n_lone_abort - l0);
    end
    checks++;
    if (o_data !== last_word) begin
      errors++;
      $display("FAIL abort_hold: got %h required %h", o_data, last_word);
    end
    got_q.delete();
    a0 = n_abort;
    tx_words = '{8'h12};
    host_frame(W, 70);
    checks++;
    if (got_q.size() != 1 || o_data !== 8'h12 || n_abort - a0 !== 0) begin
      errors++;
      $display("FAIL abort_next: got %0d words data %h abort %0d required 1 12 0",
               got_q.size(), o_data, n_abort - a0);
    end
    last_word = 8'h12;
  endtask

  task automatic test_idle_sck();
    int v0 = n_valid, s0 = n_start;
    for (int i = 0; i < 10; i++) begin
      i_mosi = i[0];
      #70 i_sck = 1'b1;
      #70 i_sck = 1'b0;
    end
    repeat (10) @(posedge i_clk);
    checks++;
    if (n_valid - v0 !== 0 || n_start - s0 !== 0) begin
      errors++;
      $display("FAIL idle_sck: got valid %0d start %0d required 0 0", n_valid - v0, n_start - s0);
    end
  endtask

  task automatic test_reset_midword();
    int v0, s0, e0, a0;
    tx_words = '{8'hB7, 8'h44};
    i_cs_n = 1'b0;
    host_bits(0, 3, 70);
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_data !== '0) begin
      errors++;
      $display("FAIL midrst_data: got %h required 00", o_data);
    end
    i_rst = 1'b0;
    v0 = n_valid; s0 = n_start; e0 = n_end; a0 = n_abort;
    host_bits(3, 2 * W - 3, 70);
    #70 i_cs_n = 1'b1;
    repeat (20) @(posedge i_clk);
    checks++;
    if (n_valid - v0 !== 0 || n_start - s0 !== 0 || n_end - e0 !== 0 || n_abort - a0 !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: got valid %0d start %0d end %0d abort %0d required 0 0 0 0",
               n_valid - v0, n_start - s0, n_end - e0, n_abort - a0);
    end
    got_q.delete();
    tx_words = '{8'h7E};
    host_frame(W, 70);
    checks++;
    if (got_q.size() != 1 || o_data !== 8'h7E || n_start - s0 !== 1 || n_end - e0 !== 1) begin
      errors++;
      $display("FAIL midrst_next: got %0d words data %h start %0d end %0d required 1 7e 1 1",
               got_q.size(), o_data, n_start - s0, n_end - e0);
    end
    last_word = 8'h7E;
  endtask

  task automatic test_random();
    for (int f = 0; f < 14; f++) begin
      int nw = $urandom_range(1, 4);
      int nbits = nw * W;
      int nfull, v0, s0, e0, a0;
      logic [W-1:0] x = W'($urandom);
      if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, W - 1);
      nfull = nbits / W;
      tx_words.delete();
      for (int i = 0; i < nw; i++) tx_words.push_back(W'($urandom));
      i_tx_data = x;
      got_q.delete();
      host_rx_q.delete();
      v0 = n_valid; s0 = n_start; e0 = n_end; a0 = n_abort;
      host_frame(nbits, $urandom_range(60, 120));
      if (nfull > 0) last_word = tx_words[nfull-1];
      checks++;
      if (n_valid - v0 !== nfull || got_q.size() != nfull) begin
        errors++;
        $display("FAIL rand%0d_valid: got %0d required %0d", f, n_valid - v0, nfull);
      end else begin
        for (int i = 0; i < nfull; i++) begin
          checks++;
          if (got_q[i] !== tx_words[i]) begin
            errors++;
            $display("FAIL rand%0d_word%0d: got %h required %h", f, i, got_q[i], tx_words[i]);
          end
        end
      end
      checks++;
      if (n_start - s0 !== 1 || n_end - e0 !== 1 || n_abort - a0 !== int'(nbits % W != 0)) begin
        errors++;
        $display("FAIL rand%0d_frame: got start %0d end %0d abort %0d required 1 1 %0d",
                 f, n_start - s0, n_end - e0, n_abort - a0, int'(nbits % W != 0));
      end
      checks++;
      if (o_data !== last_word) begin
        errors++;
        $display("FAIL rand%0d_hold: got %h required %h", f, o_data, last_word);
      end
      for (int i = 0; i < nfull && i < host_rx_q.size(); i++) begin
        checks++;
`ifdef SPI_MISO_EN
        if (host_rx_q[i] !== x) begin
          errors++;
          $display("FAIL rand%0d_miso%0d: got %h required %h", f, i, host_rx_q[i], x);
        end
`else
        if (host_rx_q[i] !== '0) begin
          errors++;
          $display("FAIL rand%0d_miso%0d: got %h required 00", f, i, host_rx_q[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_miso();
    test_abort();
    test_idle_sck();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
